// File: rtl/i2c_slave.sv
// I2C target: START/STOP decode, 7-bit address match, write-byte delivery, read-byte serving.
// Latency: SYNC_STG+1 clk from pad edge to action. I2C_STRETCH_EN enables SCL stretching on reads.
module i2c_slave #(
  parameter logic [6:0] SLV_ADDR = 7'h2D,
  parameter int         SYNC_STG = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_oe,
  output logic       scl_oe,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_req,
  output logic       busy
);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] ADDR     = 3'd1;
  localparam logic [2:0] ADDR_ACK = 3'd2;
  localparam logic [2:0] WR_DATA  = 3'd3;
  localparam logic [2:0] WR_ACK   = 3'd4;
  localparam logic [2:0] RD_DATA  = 3'd5;
  localparam logic [2:0] RD_ACK   = 3'd6;
  localparam logic [2:0] IGNORE   = 3'd7;

  logic [SYNC_STG-1:0] scl_sync, sda_sync;
  logic                scl_s, sda_s, scl_d, sda_d;
  logic                scl_r, scl_f, sda_r, sda_f;
  logic                start, stop, load_tx;
  logic [2:0]          state;
  logic [2:0]          bit_cnt;
  logic [7:0]          shift;
  logic                rw;
  logic                flag;  // ACK phase entered (ADDR_ACK/WR_ACK) or master ACKed (RD_ACK)

  // Bus idles high, so the synchronizers reset to 1 to avoid a false edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_d    <= 1'b1;
      sda_d    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STG-2:0], scl_i};
      sda_sync <= {sda_sync[SYNC_STG-2:0], sda_i};
      scl_d    <= scl_s;
      sda_d    <= sda_s;
    end
  end

  assign scl_s = scl_sync[SYNC_STG-1];
  assign sda_s = sda_sync[SYNC_STG-1];
  assign scl_r = scl_s & ~scl_d;
  assign scl_f = ~scl_s & scl_d;
  assign sda_r = sda_s & ~sda_d;
  assign sda_f = ~sda_s & sda_d;
  assign start = sda_f & scl_s;
  assign stop  = sda_r & scl_s;

  assign load_tx = ~start & ~stop & scl_f & flag &
                   (((state == ADDR_ACK) & rw) | (state == RD_ACK));

`ifdef I2C_STRETCH_EN
  localparam logic [2:0] STRETCH_CYC = 3'd4;
  logic       stretching;
  logic [2:0] str_cnt;
`else
  assign scl_oe = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      bit_cnt  <= 3'd0;
      shift    <= 8'h00;
      rw       <= 1'b0;
      flag     <= 1'b0;
      sda_oe   <= 1'b0;
      rx_data  <= 8'h00;
      rx_valid <= 1'b0;
      tx_req   <= 1'b0;
      busy     <= 1'b0;
`ifdef I2C_STRETCH_EN
      scl_oe     <= 1'b0;
      stretching <= 1'b0;
      str_cnt    <= 3'd0;
`endif
    end else begin
      rx_valid <= 1'b0;
`ifndef I2C_STRETCH_EN
      tx_req   <= 1'b0;
`endif
      if (start || stop) begin
        state   <= start ? ADDR : IDLE;
        bit_cnt <= 3'd0;
        sda_oe  <= 1'b0;
        busy    <= 1'b0;
        flag    <= 1'b0;
`ifdef I2C_STRETCH_EN
        scl_oe     <= 1'b0;
        tx_req     <= 1'b0;
        stretching <= 1'b0;
`endif
      end else begin
        case (state)
          ADDR: if (scl_r) begin
            shift   <= {shift[6:0], sda_s};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              rw   <= sda_s;
              flag <= 1'b0;
              if (shift[6:0] == SLV_ADDR) begin
                state <= ADDR_ACK;
                busy  <= 1'b1;
              end else begin
                state <= IGNORE;
              end
            end
          end
          ADDR_ACK: if (scl_f) begin
            if (!flag) begin
              sda_oe <= 1'b1;
              flag   <= 1'b1;
            end else begin
              flag   <= 1'b0;
              sda_oe <= 1'b0;
              state  <= rw ? RD_DATA : WR_DATA;
            end
          end
          WR_DATA: if (scl_r) begin
            shift   <= {shift[6:0], sda_s};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              rx_data  <= {shift[6:0], sda_s};
              rx_valid <= 1'b1;
              state    <= WR_ACK;
              flag     <= 1'b0;
            end
          end
          WR_ACK: if (scl_f) begin
            if (!flag) begin
              sda_oe <= 1'b1;
              flag   <= 1'b1;
            end else begin
              sda_oe <= 1'b0;
              flag   <= 1'b0;
              state  <= WR_DATA;
            end
          end
          RD_DATA: begin
`ifdef I2C_STRETCH_EN
            if (stretching) begin
              str_cnt <= str_cnt + 3'd1;
              if (str_cnt == STRETCH_CYC) begin
                shift      <= tx_data;
                sda_oe     <= ~tx_data[7];
                tx_req     <= 1'b0;
                scl_oe     <= 1'b0;
                stretching <= 1'b0;
              end
            end else
`endif
            if (scl_f) begin
              if (bit_cnt == 3'd7) begin
                sda_oe  <= 1'b0;
                bit_cnt <= 3'd0;
                flag    <= 1'b0;
                state   <= RD_ACK;
              end else begin
                shift   <= {shift[6:0], 1'b0};
                sda_oe  <= ~shift[6];
                bit_cnt <= bit_cnt + 3'd1;
              end
            end
          end
          RD_ACK: begin
            if (scl_r) begin
              if (!sda_s) begin
                flag <= 1'b1;
              end else begin
                state  <= IGNORE;
                sda_oe <= 1'b0;
              end
            end else if (scl_f && flag) begin
              flag  <= 1'b0;
              state <= RD_DATA;
            end
          end
          default: sda_oe <= 1'b0;
        endcase

        // Read byte load: at the end of the address ACK or after a master ACK.
        if (load_tx) begin
          bit_cnt <= 3'd0;
          tx_req  <= 1'b1;
`ifdef I2C_STRETCH_EN
          sda_oe     <= 1'b0;
          scl_oe     <= 1'b1;
          stretching <= 1'b1;
          str_cnt    <= 3'd0;
`else
          shift  <= tx_data;
          sda_oe <= ~tx_data[7];
`endif
        end
      end
    end
  end

endmodule
